hog_result_packer: RTL
======================

Name: hog_result_packer

Overview:
- Downstream of the image-processor top. Consumes the per-slide-window detection results (valid pulse, is_person, sw_id) from hog_svm.
- Packs one bit per slide window into 32-bit words and streams one frame's detection bitmap out on an AXI-Stream master, with tlast on the final word.
- Also reports a per-frame person count and sticky sequence/overflow errors.

Parameters:
- SW_W, 11, width of slide-window id and of the person counter.
- SW_NUM, 1200, slide windows per frame (1 <= SW_NUM <= 2^SW_W).
- WORD_W, 32, output word width; fixed at 32 in this revision.
- FIFO_DEPTH, 4, output word FIFO depth (power of 2, >= 2).

Ports:
- s_aclk  in  1  clock
- s_aresetn  in  1  asynchronous active-low reset
- res_valid_i  in  1  one-cycle result strobe (hog_svm o_valid)
- res_person_i  in  1  detection bit (hog_svm is_person)
- res_sw_id_i  in  SW_W  window id (hog_svm sw_id)
- m_tdata_o  out  32  packed bitmap word; bit k = window 32*word_idx+k
- m_tkeep_o  out  4  valid byte lanes
- m_tlast_o  out  1  final word of frame
- m_tvalid_o  out  1  AXI-Stream valid
- m_tready_i  in  1  AXI-Stream ready
- frame_done_o  out  1  one-cycle pulse when the final word of a frame enters the FIFO
- person_cnt_o  out  SW_W  persons in the last completed frame
- seq_err_o  out  1  sticky: res_sw_id_i != expected id
- ovf_err_o  out  1  sticky: completed word dropped because the FIFO was full
- err_clr_i  in  1  clears both sticky error flags

Behaviour:
- Reset (async assert, sync-safe release): all outputs 0. Expected id = 0, accumulator = 0, running count = 0, FIFO empty. A reset mid-frame discards the partial word and any queued words.
- Result accept: every res_valid_i cycle is accepted; there is no backpressure to hog_svm.
- Bit placement: the bit is written at position exp_id[4:0] of the accumulator. Position comes from the internal expected counter, not from res_sw_id_i.
- Sequence check: if res_sw_id_i != exp_id, seq_err_o sets the next cycle. The result is still used.
- Word completion: a word completes when exp_id[4:0] == 31 or exp_id == SW_NUM-1.
  - The completed word (accumulator OR new bit) is pushed into the FIFO at the same edge.
  - The accumulator then clears.
- Last word of frame: bits above position (SW_NUM-1) mod 32 are 0. m_tkeep_o = ceil(valid bits/8) lanes, LSB-aligned; all other words use tkeep 4'hF. m_tlast_o = 1 on that word only.
- Counters: exp_id increments on each accepted result and wraps to 0 after SW_NUM-1. The running person count adds res_person_i.
- Frame end (result with exp_id == SW_NUM-1):
  - person_cnt_o loads the running count including the current bit, and the running count clears. person_cnt_o holds until the next frame end.
  - frame_done_o pulses for 1 cycle.
- Latency: m_tvalid_o rises in the cycle after the res_valid_i that completes a word, when the FIFO was previously empty.
- FIFO/AXIS:
  - m_tdata/tkeep/tlast are driven from the FIFO head. m_tvalid_o = FIFO not empty.
  - A pop occurs on m_tvalid_o && m_tready_i. Head data must stay stable while valid && !ready.
- Full FIFO:
  - Push while full with no pop in the same cycle: the word is dropped and ovf_err_o sets. Counters, tlast and frame_done still proceed.
  - Push while full with a pop in the same cycle: the push succeeds.
- Error clear: err_clr_i clears both sticky flags. If err_clr_i coincides with a new error event, the flag is set (set wins).

Test Plan:
- SW_NUM=1200, m_tready_i=1, 1200 in-order results, is_person=1 only for ids 0, 33, 1199.
  - Required: 38 beats; beat0 = 0x00000001, beat1 = 0x00000002.
  - Beat37 = 0x00008000, tkeep = 4'b0011, tlast = 1.
  - person_cnt_o = 3 and frame_done_o pulses once, in the cycle after id 1199. No errors.
- Latency: results ids 0..31 all person=1, FIFO empty.
  - Required: m_tvalid_o = 1 with tdata 0xFFFFFFFF in the cycle after the id-31 strobe.
- Backpressure: m_tready_i=0 while 5 words complete (FIFO_DEPTH=4).
  - Required: first 4 words held stable in order; 5th word dropped; ovf_err_o = 1.
  - err_clr_i pulse -> ovf_err_o = 0.
- Sequence: feed ids 0, 1, 5, 3.
  - Required: seq_err_o = 1 from the cycle after the id-5 strobe.
  - Bits land at positions 0..3 per exp_id.
- Reset: assert s_aresetn=0 after 40 results of a frame, then release and run a full clean frame.
  - Required: all outputs read 0 during reset; no partial word emitted.
  - The new frame's beat0 reflects ids 0..31 of the new frame only.
- Back-to-back frames (2×1200 results, every cycle, ready=1).
  - Required: 76 beats total, tlast on beats 37 and 75.
  - person_cnt_o updates at each frame end.

Source files
------------

// File: rtl/hog_result_packer.sv
// hog_result_packer: packs per-slide-window detection bits into 32-bit words
// and streams one bitmap per frame over AXI-Stream. The frame's last word
// carries tlast and a reduced tkeep. Also keeps a per-frame person count and
// sticky sequence / overflow error flags.
//
// Handshake: a beat transfers on a cycle where m_tvalid_o && m_tready_i. While
// m_tvalid_o is high and m_tready_i is low, the head word (tdata/tkeep/tlast)
// holds steady. m_tvalid_o never depends on m_tready_i. The result input has
// no backpressure, so every res_valid_i strobe is consumed.
module hog_result_packer #(
  parameter int SW_W       = 11,
  parameter int SW_NUM     = 1200,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              s_aclk,
  input  logic              s_aresetn,
  input  logic              res_valid_i,
  input  logic              res_person_i,
  input  logic [SW_W-1:0]   res_sw_id_i,
  output logic [WORD_W-1:0] m_tdata_o,
  output logic [3:0]        m_tkeep_o,
  output logic              m_tlast_o,
  output logic              m_tvalid_o,
  input  logic              m_tready_i,
  output logic              frame_done_o,
  output logic [SW_W-1:0]   person_cnt_o,
  output logic              seq_err_o,
  output logic              ovf_err_o,
  input  logic              err_clr_i
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = WORD_W + 5;  // {tdata, tkeep, tlast}

  // Bits and byte lanes that are meaningful in the final word of a frame.
  localparam int LAST_BITS  = ((SW_NUM - 1) % 32) + 1;
  localparam int LAST_LANES = (LAST_BITS + 7) / 8;
  localparam logic [3:0]      LAST_KEEP = 4'((1 << LAST_LANES) - 1);
  localparam logic [SW_W-1:0] LAST_ID   = SW_W'(SW_NUM - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [SW_W-1:0]   exp_id_q, exp_id_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [SW_W-1:0]   run_cnt_q, run_cnt_d;
  logic [SW_W-1:0]   person_cnt_q, person_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              seq_err_q, seq_err_d;
  logic              ovf_err_q, ovf_err_d;
  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic              word_end;
  logic              frame_end;
  logic [WORD_W-1:0] new_word;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;
  logic              drop;

  // Next-state for counters, accumulator, result FIFO and error flags.
  always_comb begin
    word_end  = res_valid_i && ((exp_id_q[4:0] == 5'd31) || (exp_id_q == LAST_ID));
    frame_end = res_valid_i && (exp_id_q == LAST_ID);
    // Bit position follows the internal expected id, not the received id.
    new_word  = acc_q | ({{(WORD_W-1){1'b0}}, res_person_i} << exp_id_q[4:0]);
    fifo_full = (fifo_cnt_q == FULL_CNT);
    pop       = (fifo_cnt_q != '0) && m_tready_i;
    // A same-cycle pop frees the slot the push lands in.
    push_ok   = word_end && (!fifo_full || pop);
    drop      = word_end && fifo_full && !pop;

    exp_id_d     = exp_id_q;
    acc_d        = acc_q;
    run_cnt_d    = run_cnt_q;
    person_cnt_d = person_cnt_q;
    frame_done_d = frame_end;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    if (res_valid_i) begin
      exp_id_d  = frame_end ? '0 : exp_id_q + 1'b1;
      acc_d     = word_end ? '0 : new_word;
      run_cnt_d = frame_end ? '0 : run_cnt_q + SW_W'(res_person_i);
      if (frame_end) begin
        person_cnt_d = run_cnt_q + SW_W'(res_person_i);
      end
    end

    if (push_ok) begin
      mem_d[wr_ptr_q] = {new_word, (frame_end ? LAST_KEEP : 4'hF), frame_end};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push_ok) - CNT_W'(pop);

    // Clear first, then a coincident new event sets the flag again.
    seq_err_d = (err_clr_i ? 1'b0 : seq_err_q) | (res_valid_i && (res_sw_id_i != exp_id_q));
    ovf_err_d = (err_clr_i ? 1'b0 : ovf_err_q) | drop;
  end

  // State registers; reset empties the FIFO and discards any partial word.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      exp_id_q     <= '0;
      acc_q        <= '0;
      run_cnt_q    <= '0;
      person_cnt_q <= '0;
      frame_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
      ovf_err_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      exp_id_q     <= exp_id_d;
      acc_q        <= acc_d;
      run_cnt_q    <= run_cnt_d;
      person_cnt_q <= person_cnt_d;
      frame_done_q <= frame_done_d;
      seq_err_q    <= seq_err_d;
      ovf_err_q    <= ovf_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      mem_q        <= mem_d;
    end
  end

  // Stream outputs come straight from the FIFO head.
  always_comb begin
    {m_tdata_o, m_tkeep_o, m_tlast_o} = mem_q[rd_ptr_q];
    m_tvalid_o   = (fifo_cnt_q != '0);
    frame_done_o = frame_done_q;
    person_cnt_o = person_cnt_q;
    seq_err_o    = seq_err_q;
    ovf_err_o    = ovf_err_q;
  end

endmodule
